// File: rtl/freq_sweep_optimizer_if.sv
// Sequencer/ADC-side signal bundle for the resonance-search block.
// The sequencer program select is carried as programSel because "program" is a reserved word.
interface freq_sweep_optimizer_if;
    logic        swiptAlive;
    logic [1:0]  programSel;
    logic [11:0] ADC;
    logic [19:0] freq;
    logic [19:0] newFreq;
    logic [19:0] bestFreq;
    logic        freqAlgDone;

    modport master (
        output swiptAlive, programSel, ADC, freq,
        input  newFreq, bestFreq, freqAlgDone
    );

    modport slave (
        input  swiptAlive, programSel, ADC, freq,
        output newFreq, bestFreq, freqAlgDone
    );
endinterface

// File: rtl/freq_sweep_optimizer.sv
// Resonance search: steps the drive frequency, integrates ADC current per point, keeps the best point.
// Optional macro FREQ_PEAK_DETECT_EN: rank points by peak ADC sample instead of the sample sum.
module freq_sweep_optimizer #(
    parameter logic [19:0] F_START       = 20'd30000,
    parameter logic [19:0] F_STOP        = 20'd40000,
    parameter logic [19:0] F_STEP        = 20'd1000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned MEAS_LOG2     = 10
) (
    input logic                   clk,
    input logic                   nrst,
    freq_sweep_optimizer_if.slave bus
);
    localparam int unsigned ACC_W  = 12 + MEAS_LOG2;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MEAS_W = MEAS_LOG2 + 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [MEAS_W-1:0] MEAS_LAST   = MEAS_W'((1 << MEAS_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, DONE} state_t;

    state_t              state_q, state_d;
    logic [19:0]         new_freq_q, new_freq_d;
    logic [19:0]         best_freq_q, best_freq_d;
    logic                done_q, done_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    best_acc_q, best_acc_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [MEAS_W-1:0]   meas_q, meas_d;
    logic [20:0]         step_sum;
    logic [ACC_W-1:0]    adc_ext;
    logic                restart;
    logic                sweep_sel;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q     <= IDLE;
            new_freq_q  <= F_START;
            best_freq_q <= F_START;
            done_q      <= 1'b0;
            acc_q       <= '0;
            best_acc_q  <= '0;
            settle_q    <= '0;
            meas_q      <= '0;
        end else begin
            state_q     <= state_d;
            new_freq_q  <= new_freq_d;
            best_freq_q <= best_freq_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            best_acc_q  <= best_acc_d;
            settle_q    <= settle_d;
            meas_q      <= meas_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        new_freq_d  = new_freq_q;
        best_freq_d = best_freq_q;
        done_d      = done_q;
        acc_d       = acc_q;
        best_acc_d  = best_acc_q;
        settle_d    = settle_q;
        meas_d      = meas_q;
        restart     = 1'b0;
        sweep_sel   = (bus.programSel == 2'b01);
        adc_ext     = ACC_W'(bus.ADC);
        // 21-bit sum so a step past 2^20-1 cannot wrap below F_STOP
        step_sum    = {1'b0, new_freq_q} + {1'b0, F_STEP};

        case (state_q)
            IDLE: begin
                if (sweep_sel) state_d = SETTLE;
            end
            SETTLE: begin
                if (!sweep_sel) begin
                    restart = 1'b1;
                end else if (bus.freq != new_freq_q) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    acc_d    = '0;
                    state_d  = MEASURE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            MEASURE: begin
                if (!sweep_sel) begin
                    restart = 1'b1;
                end else begin
`ifdef FREQ_PEAK_DETECT_EN
                    acc_d = (adc_ext > acc_q) ? adc_ext : acc_q;
`else
                    acc_d = acc_q + adc_ext;
`endif
                    if (meas_q == MEAS_LAST) begin
                        meas_d  = '0;
                        state_d = EVAL;
                    end else begin
                        meas_d = meas_q + 1'b1;
                    end
                end
            end
            EVAL: begin
                if (!sweep_sel) begin
                    restart = 1'b1;
                end else begin
                    // strict compare: on a tie the earlier (lower) frequency is kept
                    if (acc_q > best_acc_q) begin
                        best_acc_d  = acc_q;
                        best_freq_d = new_freq_q;
                    end
                    if (step_sum > {1'b0, F_STOP}) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        new_freq_d = step_sum[19:0];
                        state_d    = SETTLE;
                    end
                end
            end
            DONE: begin
                if (bus.programSel == 2'b00) restart = 1'b1;
            end
            default: restart = 1'b1;
        endcase

        if (!bus.swiptAlive) restart = 1'b1;

        if (restart) begin
            state_d     = IDLE;
            new_freq_d  = F_START;
            best_freq_d = F_START;
            done_d      = 1'b0;
            acc_d       = '0;
            best_acc_d  = '0;
            settle_d    = '0;
            meas_d      = '0;
        end
    end

    assign bus.newFreq     = new_freq_q;
    assign bus.bestFreq    = best_freq_q;
    assign bus.freqAlgDone = done_q;
endmodule

// File: tb/tb_freq_sweep_optimizer.sv
// Scoreboard bench for freq_sweep_optimizer: per-sweep expectations from a window-sum reference model.
// Honours FREQ_PEAK_DETECT_EN in the reference model when the design is built with it.
module tb_freq_sweep_optimizer;
    localparam int S    = 20;
    localparam int ML   = 4;
    localparam int MEAS = 1 << ML;
    localparam int P    = S + MEAS + 1;
    localparam int NPT  = 11;
    localparam int unsigned F0    = 30000;
    localparam int unsigned FSTEP = 1000;
    localparam int unsigned FLAST = F0 + (NPT - 1) * FSTEP;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic hold_zero = 1'b0;
    always #5 clk = ~clk;

    freq_sweep_optimizer_if bus ();
    assign bus.freq = hold_zero ? 20'd0 : bus.newFreq;

    freq_sweep_optimizer #(
        .F_START(20'd30000),
        .F_STOP(20'd40000),
        .F_STEP(20'd1000),
        .SETTLE_CYCLES(S),
        .MEAS_LOG2(ML)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .bus(bus)
    );

    typedef struct {
        int unsigned best;
        int unsigned last;
        int unsigned done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          adc_seq[2048];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned exp_last_best = F0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_newFreq"}, bus.newFreq, F0);
        chk({tag, "_bestFreq"}, bus.bestFreq, F0);
        chk({tag, "_done"}, bus.freqAlgDone, 0);
    endtask

    // Monitor: every rising freqAlgDone is matched against the oldest pending sweep result
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.freqAlgDone && !prev_done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got freqAlgDone=1, expected no completion (cycle %0d)", cyc);
                end else begin
                    chk("best_freq", bus.bestFreq, sb[0].best);
                    chk("final_new_freq", bus.newFreq, sb[0].last);
                    chk("done_cycle", cyc, sb[0].done_cyc);
                    void'(sb.pop_front());
                end
            end
            prev_done = bus.freqAlgDone;
        end
    end

    // mode: 0 random per clock, 1 constant 2048, 2 single peak at point 5, 3 random per-point level
    // abort_kind: 0 none, 1 swiptAlive drop, 2 program leaves 01, 3 async reset pulse
    task automatic run_sweep(input int mode, input int hold, input int abort_kind, input int abort_i);
        int          len;
        int          k;
        int          base[NPT];
        longint      metric;
        longint      best_m;
        int unsigned best_f;
        int unsigned start;
        len = hold + NPT * P + 2;
        for (int j = 0; j < NPT; j++) base[j] = int'($urandom_range(0, 4080));
        for (int i = 0; i < len; i++) begin
            k = (i > hold) ? (i - hold - 1) / P : 0;
            if (k >= NPT) k = NPT - 1;
            case (mode)
                0:       adc_seq[i] = int'($urandom_range(0, 4095));
                1:       adc_seq[i] = 2048;
                2:       adc_seq[i] = (k == 5) ? 4000 : 100;
                default: adc_seq[i] = base[k] + int'($urandom_range(0, 15));
            endcase
        end
        start = cyc;
        if (abort_kind == 0) begin
            best_m = 0;
            best_f = F0;
            for (int p = 0; p < NPT; p++) begin
                metric = 0;
                for (int j = 0; j < MEAS; j++) begin
`ifdef FREQ_PEAK_DETECT_EN
                    if (adc_seq[hold + p * P + S + 1 + j] > metric) metric = adc_seq[hold + p * P + S + 1 + j];
`else
                    metric += adc_seq[hold + p * P + S + 1 + j];
`endif
                end
                if (metric > best_m) begin
                    best_m = metric;
                    best_f = F0 + p * FSTEP;
                end
            end
            exp_last_best = best_f;
            sb.push_back('{best_f, FLAST, start + 1 + hold + NPT * P});
        end
        bus.programSel = 2'b01;
        for (int i = 0; i < len; i++) begin
            bus.ADC   = 12'(adc_seq[i]);
            hold_zero = (i <= hold);
            if (hold > 0 && i == hold) chk("settle_hold_newFreq", bus.newFreq, F0);
            if (abort_kind != 0 && i == abort_i) begin
                chk("pre_abort_newFreq", bus.newFreq, F0 + ((abort_i - hold - 1) / P) * FSTEP);
                hold_zero = 1'b0;
                case (abort_kind)
                    1: begin
                        bus.swiptAlive = 1'b0;
                        @(negedge clk);
                        chk_idle("alive_abort");
                        bus.swiptAlive = 1'b1;
                        bus.programSel = 2'b00;
                    end
                    2: begin
                        bus.programSel = 2'b10;
                        @(negedge clk);
                        chk_idle("program_abort");
                        bus.programSel = 2'b00;
                    end
                    default: begin
                        #2 nrst = 1'b1;
                        #1 chk_idle("async_reset");
                        @(negedge clk);
                        nrst = 1'b0;
                        bus.programSel = 2'b00;
                    end
                endcase
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        hold_zero = 1'b0;
        chk("sweep_completed", bus.freqAlgDone, 1);
        if (!bus.freqAlgDone) sb.delete();
    endtask

    task automatic return_idle();
        bus.programSel = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.swiptAlive = 1'b1;
        bus.programSel = 2'b00;
        bus.ADC        = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        nrst = 1'b0;
        @(negedge clk);

        run_sweep(2, 0, 0, 0);
        chk("peak_model_best", exp_last_best, 35000);
        bus.programSel = 2'b10;
        repeat (100) begin
            @(negedge clk);
            chk("done_hold_flag", bus.freqAlgDone, 1);
            chk("done_hold_bestFreq", bus.bestFreq, exp_last_best);
            chk("done_hold_newFreq", bus.newFreq, FLAST);
        end
        bus.programSel = 2'b00;
        @(negedge clk);
        chk_idle("done_release");
        return_idle();

        run_sweep(1, 0, 0, 0);
        return_idle();

        run_sweep(0, 500, 0, 0);
        return_idle();

        run_sweep(3, 0, 1, 3 * P + S + 5);
        return_idle();
        run_sweep(0, 0, 0, 0);
        return_idle();

        run_sweep(3, 0, 3, 5 * P + S + 8);
        return_idle();

        run_sweep(3, 0, 2, 2 * P + 3);
        return_idle();

        repeat (4) begin
            run_sweep(($urandom_range(0, 1) == 0) ? 0 : 3, int'($urandom_range(0, 40)), 0, 0);
            return_idle();
        end

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
